tetris_cmd_rx: RTL

TETRIS_CMD_RX -- requirements
Module: tetris_cmd_rx

---
 rtl/tetris_pkg.sv | 18 +
 rtl/tetris_cmd_fifo.sv | 71 +++++++
 rtl/tetris_cmd_rx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris command path.
// The command byte is 3'b101 (header), two spare/parity bits, and a 3-bit code.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4
  } command_t;

  // Fixed marker in bits [7:5] of every legal command byte.
  localparam logic [2:0] CMD_HEADER   = 3'b101;
  // Highest code that maps onto a command_t member.
  localparam logic [2:0] CMD_MAX_CODE = 3'd4;

endpackage

// File: rtl/tetris_cmd_fifo.sv
// Synchronous command FIFO with a registered head-of-queue output.
// rd_data/rd_valid always describe the oldest stored entry (CMD_NONE when empty).
// A write into a full FIFO is taken only if the head is popped in the same cycle.
module tetris_cmd_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     wr_en,
  input  command_t wr_data,
  input  logic     rd_en,
  output command_t rd_data,
  output logic     rd_valid,
  output logic     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  command_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]     count_reg, count_next;
  command_t           head_reg, head_next;
  logic               valid_reg;
  logic               push, pop;

  assign full     = (count_reg == FULL_CNT);
  assign rd_data  = head_reg;
  assign rd_valid = valid_reg;

  // Pointer/occupancy update and next head value; a write that lands in the
  // slot becoming the head is forwarded so the output never lags a cycle.
  always_comb begin
    pop         = valid_reg & rd_en;
    push        = wr_en & (~full | pop);
    wr_ptr_next = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    count_next  = count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    head_next   = CMD_NONE;
    if (count_next != '0) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) head_next = wr_data;
      else                                      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= CMD_NONE;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      valid_reg  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/tetris_cmd_rx.sv
// SPI (mode 0, MSB first) command receiver for the Tetris core.
// Bytes are synchronised into clk, validated, and legal non-NONE commands are
// queued in tetris_cmd_fifo. Optional build macro TETRIS_CMD_PARITY_EN makes
// bit 3 a check bit over the code bits; without it bits [4:3] are ignored.
module tetris_cmd_rx
  import tetris_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output command_t   cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       overflow,
  output logic [7:0] bad_cnt,
  input  logic       clr_status
);

  // Bundle order {mosi, cs_n, sck}; idle levels are sck=0, cs_n=1.
  localparam int              SYNC_W    = 3;
  localparam logic [SYNC_W-1:0] SYNC_IDLE = 3'b010;

  logic [SYNC_W-1:0] sync_in, sync_out;
  logic              sck_s, cs_s, mosi_s;

  assign sync_in = {mosi, cs_n, sck};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
      logic [1:0] sync_reg;
      // Two-flop synchroniser for one asynchronous SPI line.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg <= {2{SYNC_IDLE[gi]}};
        else          sync_reg <= {sync_reg[0], sync_in[gi]};
      end
      assign sync_out[gi] = sync_reg[1];
    end
  endgenerate

  assign sck_s  = sync_out[0];
  assign cs_s   = sync_out[1];
  assign mosi_s = sync_out[2];

  logic       sck_prev_reg, cs_prev_reg;
  logic       sck_rise, cs_fall;
  logic [2:0] bit_cnt_reg, bit_cnt_next, cnt_base;
  logic [6:0] shift_reg, shift_next;
  logic [7:0] byte_word;
  logic       byte_done, hdr_ok, code_ok, par_ok, byte_ok;
  logic       bad_byte, good_cmd;
  logic       wr_req_reg;
  command_t   wr_cmd_reg;
  logic       fifo_full, pop, ovf_set;
  logic       unused_bits;

  assign sck_rise  = sck_s & ~sck_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  // A frame start restarts byte alignment even if an sck edge arrives with it.
  assign cnt_base  = cs_fall ? 3'd0 : bit_cnt_reg;
  assign byte_word = {shift_reg, mosi_s};
  assign byte_done = sck_rise & ~cs_s & (cnt_base == 3'd7);

  assign hdr_ok  = (byte_word[7:5] == CMD_HEADER);
  assign code_ok = (byte_word[2:0] <= CMD_MAX_CODE);
`ifdef TETRIS_CMD_PARITY_EN
  // Bit 3 must equal the XOR of the three code bits.
  assign par_ok  = (byte_word[3] == ^byte_word[2:0]);
`else
  assign par_ok  = 1'b1;
`endif
  assign byte_ok     = hdr_ok & code_ok & par_ok;
  assign bad_byte    = byte_done & ~byte_ok;
  // CMD_NONE is a keep-alive: accepted but never queued.
  assign good_cmd    = byte_done & byte_ok & (byte_word[2:0] != 3'd0);
  assign unused_bits = ^byte_word[4:3];

  // Bit counter and shift register; cs_n high drops any partial byte.
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    if (cs_s) begin
      bit_cnt_next = 3'd0;
    end else begin
      bit_cnt_next = cnt_base;
      if (sck_rise) begin
        bit_cnt_next = cnt_base + 3'd1;
        shift_next   = {shift_reg[5:0], mosi_s};
      end
    end
  end

  // Edge-detect history, byte assembly and the one-cycle FIFO write request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_prev_reg <= 1'b0;
      cs_prev_reg  <= 1'b1;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 7'd0;
      wr_req_reg   <= 1'b0;
      wr_cmd_reg   <= CMD_NONE;
    end else begin
      sck_prev_reg <= sck_s;
      cs_prev_reg  <= cs_s;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      wr_req_reg   <= good_cmd;
      wr_cmd_reg   <= command_t'(byte_word[2:0]);
    end
  end

  tetris_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_req_reg),
    .wr_data  (wr_cmd_reg),
    .rd_en    (cmd_ready),
    .rd_data  (cmd),
    .rd_valid (cmd_valid),
    .full     (fifo_full)
  );

  assign pop     = cmd_valid & cmd_ready;
  assign ovf_set = wr_req_reg & fifo_full & ~pop;

  // Sticky overflow flag and saturating reject counter; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      bad_cnt  <= 8'd0;
    end else if (clr_status) begin
      overflow <= 1'b0;
      bad_cnt  <= 8'd0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (bad_byte && (bad_cnt != 8'hFF)) bad_cnt <= bad_cnt + 8'd1;
    end
  end

endmodule
